// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: command codes, controller states and window size shared by the LCD controller
package lcd_ctrl_pkg;
  localparam int WIN = 4;
  localparam logic [3:0] CMD_WRITE  = 4'h0;
  localparam logic [3:0] CMD_UP     = 4'h1;
  localparam logic [3:0] CMD_DOWN   = 4'h2;
  localparam logic [3:0] CMD_LEFT   = 4'h3;
  localparam logic [3:0] CMD_RIGHT  = 4'h4;
  localparam logic [3:0] CMD_MAX    = 4'h5;
  localparam logic [3:0] CMD_MIN    = 4'h6;
  localparam logic [3:0] CMD_AVG    = 4'h7;
  localparam logic [3:0] CMD_CCW    = 4'h8;
  localparam logic [3:0] CMD_CW     = 4'h9;
  localparam logic [3:0] CMD_MIRX   = 4'hA;
  localparam logic [3:0] CMD_MIRY   = 4'hB;
  localparam logic [3:0] CMD_RELOAD = 4'hC;
  typedef enum logic [2:0] {S_FETCH, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/lcd_win_stat.sv
// lcd_win_stat: max, min and floor-average of the 4x4 operation window
module lcd_win_stat
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] pix [WIN*WIN],
  output logic [DW-1:0] mx,
  output logic [DW-1:0] mn,
  output logic [DW-1:0] avg
);
  logic [DW+3:0] sum;
  always_comb begin
    mx = pix[0];
    mn = pix[0];
    sum = '0;
    for (int i = 0; i < WIN * WIN; i++) begin
      mx = pix[i] > mx ? pix[i] : mx;
      mn = pix[i] < mn ? pix[i] : mn;
      sum = sum + {4'b0, pix[i]};
    end
    avg = sum[DW+3:4];
  end
endmodule

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: N x N image controller; ROM fetch, 4x4 window commands, RAM write-out
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_LOG2 = 3,
  parameter int DW = 8,
  localparam int N = 2 ** IMG_LOG2,
  localparam int AW = 2 * IMG_LOG2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_valid,
  output logic [AW-1:0] IRAM_A,
  output logic [DW-1:0] IRAM_D,
  output logic          busy,
  output logic          done
);
  localparam int WW = WIN * WIN;
  localparam logic [AW-1:0] LAST = AW'(N * N - 1);
  localparam logic [IMG_LOG2-1:0] LO = IMG_LOG2'(2);
  localparam logic [IMG_LOG2-1:0] HI = IMG_LOG2'(N - 2);
  localparam logic [IMG_LOG2-1:0] MID = IMG_LOG2'(N / 2);
  state_t state, state_d;
  logic [3:0] op;
  logic [IMG_LOG2-1:0] x, y;
  logic [DW-1:0] img [N*N];
  logic [AW-1:0] widx [WW];
  logic [DW-1:0] w [WW];
  logic [DW-1:0] nw [WW];
  logic [DW-1:0] mx, mn, avg;
  logic accept, fetch_end, wr_win;

  assign accept = (state == S_IDLE || state == S_DONE) && cmd_valid;
  assign fetch_end = state == S_FETCH && IROM_rd && IROM_A == LAST;
  assign wr_win = state == S_EXEC && op >= CMD_MAX && op <= CMD_MIRY;
  assign busy = !(state == S_IDLE || state == S_DONE);
  assign done = state == S_DONE;
  assign IRAM_valid = state == S_WRITE;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH: state_d = fetch_end ? S_IDLE : S_FETCH;
      S_IDLE, S_DONE: state_d = !cmd_valid ? state : cmd == CMD_WRITE ? S_WRITE : cmd == CMD_RELOAD ? S_FETCH : S_EXEC;
      S_EXEC: state_d = S_IDLE;
      S_WRITE: state_d = IRAM_A == LAST ? S_DONE : S_WRITE;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        widx[r*WIN+c] = AW'((int'(y) - 2 + r) * N + int'(x) - 2 + c);
        w[r*WIN+c] = img[widx[r*WIN+c]];
      end

  // Rotations and mirrors are pure index remaps of the gathered window
  always_comb
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        nw[r*WIN+c] = op == CMD_MAX ? mx : op == CMD_MIN ? mn : op == CMD_AVG ? avg :
                      op == CMD_CCW ? w[c*WIN+WIN-1-r] : op == CMD_CW ? w[(WIN-1-c)*WIN+r] :
                      op == CMD_MIRX ? w[(WIN-1-r)*WIN+c] : w[r*WIN+WIN-1-c];

  lcd_win_stat #(.DW(DW)) stat (.pix(w), .mx(mx), .mn(mn), .avg(avg));

  // Image store has no reset so contents survive an abort
  always_ff @(posedge clk) begin
    if (state == S_FETCH && IROM_rd) img[IROM_A] <= IROM_Q;
    if (wr_win) for (int i = 0; i < WW; i++) img[widx[i]] <= nw[i];
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      IROM_rd <= 1'b0;
      IROM_A <= '0;
      IRAM_A <= '0;
      IRAM_D <= '0;
      x <= MID;
      y <= MID;
      op <= CMD_WRITE;
    end else begin
      if (state == S_FETCH) begin
        IROM_rd <= !fetch_end;
        IROM_A <= IROM_rd && !fetch_end ? IROM_A + 1'b1 : '0;
      end
      if (accept) begin
        op <= cmd;
        if (cmd == CMD_RELOAD) begin
          x <= MID;
          y <= MID;
        end
        if (cmd == CMD_WRITE) begin
          IRAM_A <= '0;
          IRAM_D <= img[0];
        end
      end
      if (state == S_WRITE && IRAM_A != LAST) begin
        IRAM_A <= IRAM_A + 1'b1;
        IRAM_D <= img[IRAM_A + 1'b1];
      end
      if (state == S_EXEC) begin
        y <= op == CMD_UP && y > LO ? y - 1'b1 : op == CMD_DOWN && y < HI ? y + 1'b1 : y;
        x <= op == CMD_LEFT && x > LO ? x - 1'b1 : op == CMD_RIGHT && x < HI ? x + 1'b1 : x;
      end
    end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed and randomized command sequences checked against a behavioural image model
module tb_lcd_ctrl_param;
  localparam int N = 8;
  localparam int NN = N * N;
  localparam int LIM = 4000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] cmd = 4'h0;
  logic cmd_valid = 1'b0;
  logic irom_rd, iram_valid, busy, done;
  logic [5:0] irom_a, iram_a;
  logic [7:0] irom_q = 8'h0;
  logic [7:0] iram_d;
  logic [7:0] rom [NN];
  logic [7:0] ram [NN];
  logic [7:0] mimg [NN];
  int mx, my;
  int checks = 0, failures = 0;
  int wr_cnt = 0, order_err = 0, excl_err = 0;
  logic prev_v = 1'b0;
  logic [5:0] prev_a = 6'd0;
  logic done_acc;

  always #5 clk = ~clk;

  lcd_ctrl_param #(.IMG_LOG2(3), .DW(8)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_rd(irom_rd), .IROM_A(irom_a), .IROM_Q(irom_q),
    .IRAM_valid(iram_valid), .IRAM_A(iram_a), .IRAM_D(iram_d),
    .busy(busy), .done(done)
  );

  // ROM and RAM models act on the falling edge
  always @(negedge clk) begin
    if (irom_rd) irom_q <= rom[irom_a];
    if (irom_rd && iram_valid) excl_err <= excl_err + 1;
    if (iram_valid) begin
      ram[iram_a] <= iram_d;
      if (iram_a != (prev_v ? prev_a + 6'd1 : 6'd0)) order_err <= order_err + 1;
      wr_cnt <= prev_v ? wr_cnt + 1 : 1;
    end
    prev_v <= iram_valid;
    prev_a <= iram_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int r, input int c);
    return (my - 2 + r) * N + mx - 2 + c;
  endfunction

  task automatic m_reload();
    for (int a = 0; a < NN; a++) mimg[a] = rom[a];
    mx = N / 2;
    my = N / 2;
  endtask

  task automatic m_apply(input logic [3:0] op);
    int t [4][4];
    int hi, lo, sum;
    hi = 0;
    lo = 255;
    sum = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        t[r][c] = int'(mimg[pix(r, c)]);
        hi = t[r][c] > hi ? t[r][c] : hi;
        lo = t[r][c] < lo ? t[r][c] : lo;
        sum += t[r][c];
      end
    case (op)
      4'h1: if (my > 2) my--;
      4'h2: if (my < N - 2) my++;
      4'h3: if (mx > 2) mx--;
      4'h4: if (mx < N - 2) mx++;
      4'h5, 4'h6, 4'h7:
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            mimg[pix(r, c)] = 8'(op == 4'h5 ? hi : op == 4'h6 ? lo : sum / 16);
      4'h8, 4'h9, 4'hA, 4'hB:
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            mimg[pix(r, c)] = 8'(op == 4'h8 ? t[c][3-r] : op == 4'h9 ? t[3-c][r] :
                                 op == 4'hA ? t[3-r][c] : t[r][3-c]);
      4'hC: m_reload();
      default: ;
    endcase
  endtask

  task automatic send(input logic [3:0] op, output int nb);
    nb = 0;
    while (busy && nb < LIM) begin @(negedge clk); nb++; end
    cmd = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_acc = done;
    m_apply(op);
    nb = 0;
    while (busy && nb < LIM) begin @(negedge clk); nb++; end
    if (busy) begin
      checks++;
      failures++;
      $error("FAIL busy_timeout observed=busy expected=idle");
    end
  endtask

  task automatic write_cmp(input string tag);
    int nb;
    send(4'h0, nb);
    chk({tag, "_wr_cycles"}, nb, 64);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wr_count"}, wr_cnt, 64);
    chk({tag, "_wr_order"}, order_err, 0);
    for (int a = 0; a < NN; a++) chk($sformatf("%s_px%0d", tag, a), ram[a], mimg[a]);
  endtask

  task automatic do_reset();
    int nb;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_rom_rd", irom_rd, 0);
    chk("rst_rom_a", irom_a, 0);
    chk("rst_ram_valid", iram_valid, 0);
    chk("rst_ram_a", iram_a, 0);
    chk("rst_ram_d", iram_d, 0);
    @(negedge clk);
    reset = 1'b1;
    nb = 0;
    while (busy && nb < LIM) begin @(negedge clk); nb++; end
    chk("fetch_busy_cycles", nb, 65);
    m_reload();
  endtask

  initial begin
    int nb;
    logic [3:0] op;
    for (int a = 0; a < NN; a++) rom[a] = 8'(a);
    do_reset();
    write_cmp("init");
    send(4'h5, nb);
    chk("max_busy", nb, 1);
    write_cmp("max");
    chk("max_px18", ram[18], 8'h2D);
    chk("max_px45", ram[45], 8'h2D);
    do_reset();
    send(4'h6, nb);
    write_cmp("min");
    chk("min_px18", ram[18], 8'h12);
    do_reset();
    send(4'h7, nb);
    write_cmp("avg");
    chk("avg_px29", ram[29], 8'h1F);
    chk("avg_px17", ram[17], 8'h11);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(4'h4, nb);
      chk("right_busy", nb, 1);
    end
    send(4'h5, nb);
    write_cmp("right_max");
    chk("right_px20", ram[20], 8'h2F);
    chk("right_px47", ram[47], 8'h2F);
    chk("right_px19", ram[19], 8'h13);
    do_reset();
    send(4'h9, nb);
    write_cmp("cw");
    chk("cw_px18", ram[18], 8'h2A);
    chk("cw_px21", ram[21], 8'h12);
    chk("cw_px45", ram[45], 8'h15);
    send(4'h8, nb);
    write_cmp("ccw");
    chk("ccw_restore_px18", ram[18], 8'h12);
    do_reset();
    send(4'hA, nb);
    write_cmp("mirx");
    chk("mirx_px18", ram[18], 8'h2A);
    chk("mirx_px42", ram[42], 8'h12);
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < NN; a++) rom[a] = 8'($urandom);
      do_reset();
      for (int j = 0; j < 16; j++) begin
        op = 4'($urandom_range(1, 14));
        if (op == 4'hC) op = 4'hF;
        send(op, nb);
        chk("rand_busy", nb, 1);
      end
      write_cmp("rand");
      for (int j = 0; j < 6; j++) begin
        op = 4'($urandom_range(1, 11));
        send(op, nb);
        chk("rand_after_done_busy", nb, 1);
      end
      write_cmp("rand_after_done");
    end
    for (int a = 0; a < NN; a++) rom[a] = 8'(a * 7 + 3);
    send(4'hC, nb);
    chk("reload_done_drop", done_acc, 0);
    chk("reload_busy", nb, 65);
    write_cmp("reload");
    cmd = 4'h0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    nb = 0;
    while (iram_a != 6'd20 && nb < LIM) begin @(negedge clk); nb++; end
    chk("abort_at_px20", iram_a, 20);
    chk("abort_valid_before", iram_valid, 1);
    reset = 1'b0;
    #1;
    chk("abort_valid", iram_valid, 0);
    chk("abort_busy", busy, 1);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    nb = 0;
    while (busy && nb < LIM) begin
      cmd = 4'h5;
      cmd_valid = (nb % 5 == 2);
      @(negedge clk);
      nb++;
    end
    cmd_valid = 1'b0;
    chk("refetch_busy", nb, 65);
    m_reload();
    write_cmp("post_abort");
    chk("rd_valid_exclusive", excl_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised next-generation LCD image controller. It fetches an N×N image of DW-bit pixels from the image ROM into an internal register array. It then applies host commands to a fixed 4×4 operation window: shift, max, min, average, rotate, mirror and reload. On the write command it streams the whole image to the image RAM. Compared with the fixed 8×8 controller, it adds width/size generics, a reload command, and acceptance of further commands after done.

Parameters:
IMG_LOG2, 3, log2 of image side N (N=8 default; legal 2..5)
DW, 8, pixel width in bits
Derived localparams: N=2**IMG_LOG2, AW=2*IMG_LOG2, WIN=4 (fixed)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low
cmd  input  4  command code
cmd_valid  input  1  command strobe, sampled at posedge while busy=0
IROM_rd  output  1  ROM read enable
IROM_A  output  AW  ROM address
IROM_Q  input  DW  ROM data; ROM registers it on negedge when IROM_rd=1
IRAM_valid  output  1  RAM write enable; RAM writes on negedge
IRAM_A  output  AW  RAM address
IRAM_D  output  DW  RAM data
busy  output  1  controller cannot accept cmd
done  output  1  image write-out complete

Behaviour:
- Reset (async, reset=0): busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, op point (x,y)=(N/2,N/2), state=FETCH. The image array is not cleared.
- Reset asserted mid-operation (fetch, exec or write) aborts immediately and restarts from FETCH after release.
- States: FETCH, IDLE, EXEC, WRITE, DONE.
- FETCH:
  - IROM_rd=1, IROM_A steps 0..N*N-1, one address per cycle.
  - The pixel for address a is captured at the posedge after the cycle in which IROM_A=a.
  - Fetch lasts N*N+1 cycles. Then IROM_rd=0, busy=0, state→IDLE.
- IDLE: busy=0. cmd_valid=1 at a posedge latches cmd; busy=1 next cycle. cmd_valid while busy=1 is ignored (not queued).
- EXEC (1 cycle) for cmds 1..B: the image/op point updates at the end of EXEC; busy returns to 0 the following cycle.
- Window: rows y-2..y+1, cols x-2..x+1. Indices w[r][c], r,c∈0..3. Pixel address = row*N+col.
- Commands:
  - 0 WRITE: enter WRITE.
  - 1 shift up (y-1); 2 down (y+1); 3 left (x-1); 4 right (x+1). x,y clamp to [2,N-2]; an out-of-range shift is a no-op but still takes the normal busy cycle.
  - 5 MAX: all 16 window pixels ← the maximum value.
  - 6 MIN: all 16 window pixels ← the minimum value.
  - 7 AVG: all 16 window pixels ← floor(sum/16). Sum width DW+4, no overflow.
  - 8 CCW rotate: w'[r][c]=w[c][3-r].
  - 9 CW rotate: w'[r][c]=w[3-c][r].
  - A mirror X: w'[r][c]=w[3-r][c].
  - B mirror Y: w'[r][c]=w[r][3-c].
  - C RELOAD: op point ← (N/2,N/2), state→FETCH (busy held).
  - D–F: no-op, one busy cycle.
- WRITE:
  - IRAM_valid=1, IRAM_A 0..N*N-1 ascending, IRAM_D=image[IRAM_A], all registered. N*N cycles.
  - The next cycle IRAM_valid=0, done=1, busy=0, state→DONE.
- DONE: done held 1 until the next accepted cmd. That cmd clears done next cycle and is executed as from IDLE, so processing can continue after done.
- IROM_rd and IRAM_valid are never both 1.

Decomposition:
- Package lcd_ctrl_pkg: cmd code localparams (CMD_WRITE..CMD_RELOAD), state enum, WIN=4.
- One sub-module, lcd_win_stat: combinational max/min/floor-average over 16 DW-bit inputs, parametrised on DW.
- Shift/rotate/mirror index mapping stays in the top level.

Test Plan:
- Image pixel[a]=a (N=8). After reset release: busy=1 for exactly 65 cycles → busy=0. Then WRITE → IRAM[0..63]=0..63 in order, done=1 after the 64th write.
- Default window (x=4,y=4): MAX → addrs {18..21,26..29,34..37,42..45}=0x2D. Repeat from fresh reset with MIN → 0x12; with AVG → 504/16 → 0x1F. WRITE confirms; other pixels unchanged.
- RIGHT ×3 (third is a no-op at x=6), then MAX → window cols 4..7, rows 2..5 all =0x2F. busy is 1 for one cycle per shift.
- CW at default window → addr18=0x2A, addr21=0x12, addr45=0x15. Separately, MIRROR X → addr18=0x2A, addr42=0x12. CCW after CW restores the original image.
- After done=1: RELOAD with a ROM holding a different image, then WRITE → the RAM matches the new image; done drops the cycle after RELOAD is accepted.
- reset=0 asserted during WRITE at pixel 20 → IRAM_valid=0 and busy=1 immediately. After release: full 65-cycle refetch; cmd_valid pulses during busy are ignored.
